// File: rtl/trivium_stream_core_pkg.sv
// Shared Trivium constants, FSM state type and the key/IV load pattern.
package trivium_pkg;
  localparam int ST_W         = 288;
  localparam int KEY_W        = 80;
  localparam int IV_W         = 80;
  localparam int WARMUP_STEPS = 1152;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, EXHAUSTED} state_t;

  // st[i] holds s(i+1): key in s1..80, IV in s94..173, s286..288 set.
  function automatic logic [ST_W-1:0] trivium_init(input logic [KEY_W-1:0] key,
                                                   input logic [IV_W-1:0]  iv);
    logic [ST_W-1:0] st;
    st          = '0;
    st[79:0]    = key;
    st[172:93]  = iv;
    st[287:285] = 3'b111;
    return st;
  endfunction
endpackage

// File: rtl/trivium_stream_core_if.sv
// Valid/ready data path into and out of the Trivium core.
interface trivium_stream_core_if #(parameter int W = 8) ();
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;

  modport master (output s_data, s_valid, s_last, m_ready,
                  input  s_ready, m_data, m_valid, m_last);
  modport slave  (input  s_data, s_valid, s_last, m_ready,
                  output s_ready, m_data, m_valid, m_last);
endinterface

// File: rtl/trivium_stream_core_step.sv
// One combinational Trivium step: produces keystream bit z and the next state.
module trivium_step
  import trivium_pkg::*;
(
  input  logic [ST_W-1:0] st_i,
  output logic [ST_W-1:0] st_o,
  output logic            z_o
);
  logic t1, t2, t3;
  logic n1, n2, n3;

  assign t1  = st_i[65]  ^ st_i[92];
  assign t2  = st_i[161] ^ st_i[176];
  assign t3  = st_i[242] ^ st_i[287];
  assign z_o = t1 ^ t2 ^ t3;

  assign n1 = t1 ^ (st_i[90]  & st_i[91])  ^ st_i[170];
  assign n2 = t2 ^ (st_i[174] & st_i[175]) ^ st_i[263];
  assign n3 = t3 ^ (st_i[285] & st_i[286]) ^ st_i[68];

  // Three shift registers, each fed by the feedback of the previous one.
  assign st_o = {st_i[286:177], n2, st_i[175:93], n1, st_i[91:0], n3};
endmodule

// File: rtl/trivium_stream_core.sv
// Trivium engine: W steps per cycle, 1152-step warm-up, keystream XOR on a
// valid/ready stream with a one-entry output register and a per-load word limit.
module trivium_stream_core
  import trivium_pkg::*;
#(
  parameter int          W         = 8,
  parameter logic [63:0] MAX_WORDS = 64'h0400_0000_0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_i,
  input  logic [IV_W-1:0]  iv_i,
  input  logic             load_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             err_o,
  trivium_stream_core_if.slave sif
);
  localparam logic [10:0] WARM_LAST = 11'(WARMUP_STEPS / W - 1);

  state_t          state_q, state_d;
  logic [ST_W-1:0] st_q, st_d;
  logic [10:0]     warm_cnt_q, warm_cnt_d;
  logic [63:0]     word_cnt_q, word_cnt_d;
  logic            m_valid_q, m_valid_d;
  logic [W-1:0]    m_data_q, m_data_d;
  logic            m_last_q, m_last_d;

  logic [ST_W-1:0] chain [0:W];
  logic [W-1:0]    ks;
  logic            accept;

  assign chain[0] = st_q;
  for (genvar j = 0; j < W; j++) begin : g_step
    trivium_step u_step (.st_i(chain[j]), .st_o(chain[j+1]), .z_o(ks[j]));
  end

  // A load in the same cycle blocks the handshake so no word is half-taken.
  assign sif.s_ready = (state_q == RUN) & ~load_i & (~m_valid_q | sif.m_ready);
  assign accept      = sif.s_valid & sif.s_ready;

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    warm_cnt_d = warm_cnt_q;
    word_cnt_d = word_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    if (load_i) begin
      st_d       = trivium_init(key_i, iv_i);
      warm_cnt_d = '0;
      word_cnt_d = '0;
      m_valid_d  = 1'b0;
      state_d    = WARMUP;
    end else begin
      if (m_valid_q && sif.m_ready) m_valid_d = 1'b0;
      case (state_q)
        WARMUP: begin
          st_d       = chain[W];
          warm_cnt_d = warm_cnt_q + 11'd1;
          if (warm_cnt_q == WARM_LAST) state_d = RUN;
        end
        RUN: begin
          if (accept) begin
            st_d       = chain[W];
            word_cnt_d = word_cnt_q + 64'd1;
            m_valid_d  = 1'b1;
            m_data_d   = sif.s_data ^ ks;
            m_last_d   = sif.s_last;
            if (sif.s_last)                   state_d = IDLE;
            else if (word_cnt_d == MAX_WORDS) state_d = EXHAUSTED;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      st_q       <= '0;
      warm_cnt_q <= '0;
      word_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_q       <= st_d;
      warm_cnt_q <= warm_cnt_d;
      word_cnt_q <= word_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
    end
  end

  assign busy_o      = (state_q == WARMUP);
  assign ready_o     = (state_q == RUN);
  assign err_o       = (state_q == EXHAUSTED);
  assign sif.m_valid = m_valid_q;
  assign sif.m_data  = m_data_q;
  assign sif.m_last  = m_last_q;
endmodule

// File: tb/tb_trivium_stream_core.sv
// Bench for trivium_stream_core: bit-serial reference model, W=1/8/64 instances,
// a scoreboard on the W=8 stream and a MAX_WORDS=4 instance for the limit.
`timescale 1ns/1ps
module tb_trivium_stream_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [79:0] key8, iv8, key1, iv1, key64, iv64, keyl, ivl;
  logic        load8, load1, load64, loadl;
  logic        busy8, ready8, err8, busy1, ready1, err1;
  logic        busy64, ready64, err64, busyl, readyl, errl;

  trivium_stream_core_if #(.W(8))  if8 ();
  trivium_stream_core_if #(.W(1))  if1 ();
  trivium_stream_core_if #(.W(64)) if64 ();
  trivium_stream_core_if #(.W(8))  ifl ();

  trivium_stream_core #(.W(8)) dut8 (.clk(clk), .rst(rst), .key_i(key8), .iv_i(iv8),
    .load_i(load8), .busy_o(busy8), .ready_o(ready8), .err_o(err8), .sif(if8.slave));
  trivium_stream_core #(.W(1)) dut1 (.clk(clk), .rst(rst), .key_i(key1), .iv_i(iv1),
    .load_i(load1), .busy_o(busy1), .ready_o(ready1), .err_o(err1), .sif(if1.slave));
  trivium_stream_core #(.W(64)) dut64 (.clk(clk), .rst(rst), .key_i(key64), .iv_i(iv64),
    .load_i(load64), .busy_o(busy64), .ready_o(ready64), .err_o(err64), .sif(if64.slave));
  trivium_stream_core #(.W(8), .MAX_WORDS(64'd4)) dutl (.clk(clk), .rst(rst), .key_i(keyl),
    .iv_i(ivl), .load_i(loadl), .busy_o(busyl), .ready_o(readyl), .err_o(errl), .sif(ifl.slave));

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t        sbq [$];
  logic [7:0]  capq [$];
  logic        hold_v;
  logic [8:0]  hold_d;
  logic [7:0]  din [64];
  logic [7:0]  dexp [64];
  logic [7:0]  pt [32];
  logic [1023:0] ksr;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Classic three-register Trivium, one step per iteration.
  function automatic logic [1023:0] model_ks(input logic [79:0] k, input logic [79:0] v);
    logic [93:1]  a;
    logic [84:1]  b;
    logic [111:1] c;
    logic t1, t2, t3;
    logic [1023:0] z;
    a = '0; b = '0; c = '0; z = '0;
    for (int i = 1; i <= 80; i++) begin a[i] = k[i-1]; b[i] = v[i-1]; end
    c[109] = 1'b1; c[110] = 1'b1; c[111] = 1'b1;
    for (int n = 0; n < 1152 + 1024; n++) begin
      t1 = a[66] ^ a[93];
      t2 = b[69] ^ b[84];
      t3 = c[66] ^ c[111];
      if (n >= 1152) z[n-1152] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (a[91] & a[92]) ^ b[78];
      t2 = t2 ^ (b[82] & b[83]) ^ c[87];
      t3 = t3 ^ (c[109] & c[110]) ^ a[69];
      a = {a[92:1], t3};
      b = {b[83:1], t1};
      c = {c[110:1], t2};
    end
    return z;
  endfunction

  // One W=8 cycle: called at a negedge, returns at the next negedge.
  task automatic cyc8(input logic v, input logic [7:0] d, input logic l,
                      input logic [7:0] e, input logic mr, output logic acc);
    exp_t x;
    if8.s_valid = v; if8.s_data = d; if8.s_last = l; if8.m_ready = mr;
    #1;
    acc = v & if8.s_ready;
    if (if8.m_valid && mr) begin
      if (sbq.size() == 0) check("sb_underflow", 1, 0);
      else begin
        x = sbq.pop_front();
        check("m_data", if8.m_data, x.d);
        check("m_last", if8.m_last, x.l);
        capq.push_back(if8.m_data);
      end
    end else if (if8.m_valid && hold_v) begin
      check("stall_stable", {if8.m_last, if8.m_data}, hold_d);
    end
    hold_v = if8.m_valid & ~mr;
    hold_d = {if8.m_last, if8.m_data};
    if (acc) sbq.push_back('{e, l});
    @(negedge clk);
  endtask

  task automatic count_busy8(output int bn);
    bn = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ready8) break;
      bn += int'(busy8);
      @(negedge clk);
    end
    check("warm_timeout", ready8, 1);
  endtask

  task automatic load_main(input logic [79:0] k, input logic [79:0] v, output int bn);
    key8 = k; iv8 = v; load8 = 1'b1; if8.s_valid = 1'b0; if8.m_ready = 1'b1;
    @(negedge clk);
    load8 = 1'b0; sbq.delete(); hold_v = 1'b0;
    count_busy8(bn);
  endtask

  task automatic send(input int n, input int stall, output int ncyc);
    int   idx;
    logic acc, mr;
    idx = 0; ncyc = 0;
    while (idx < n && ncyc < 2000) begin
      mr = ($urandom_range(99) >= stall);
      cyc8(1'b1, din[idx], idx == n - 1, dexp[idx], mr, acc);
      ncyc++;
      if (acc) idx++;
    end
    if8.s_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 100 && sbq.size() > 0; i++) cyc8(1'b0, 8'h0, 1'b0, 8'h0, 1'b1, acc);
    check("sb_empty", sbq.size(), 0);
    check("idle_after_last", {busy8, ready8, err8, if8.m_valid, if8.s_ready}, 0);
  endtask

  task automatic run_w1(input logic [79:0] k, input logic [79:0] v,
                        output int bn, output logic [255:0] bits);
    int cnt;
    cnt = 0; bn = 0; bits = '0;
    key1 = k; iv1 = v; load1 = 1'b1; if1.s_valid = 1'b0; if1.m_ready = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    for (int i = 0; i < 1500 && !ready1; i++) begin bn += int'(busy1); @(negedge clk); end
    if1.s_valid = 1'b1;
    for (int i = 0; i < 400 && cnt < 256; i++) begin
      #1;
      if (if1.m_valid) begin bits[cnt] = if1.m_data[0]; cnt++; end
      @(negedge clk);
    end
    if1.s_valid = 1'b0;
  endtask

  task automatic run_w64(input logic [79:0] k, input logic [79:0] v,
                         output int bn, output logic [255:0] bits);
    int cnt;
    cnt = 0; bn = 0; bits = '0;
    key64 = k; iv64 = v; load64 = 1'b1; if64.s_valid = 1'b0; if64.m_ready = 1'b1;
    @(negedge clk);
    load64 = 1'b0;
    for (int i = 0; i < 100 && !ready64; i++) begin bn += int'(busy64); @(negedge clk); end
    if64.s_valid = 1'b1;
    for (int i = 0; i < 20 && cnt < 4; i++) begin
      #1;
      if (if64.m_valid) begin bits[cnt*64 +: 64] = if64.m_data; cnt++; end
      @(negedge clk);
    end
    if64.s_valid = 1'b0;
  endtask

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          nw;
    int          stall;
    int          exp_busy;
  } vec_t;
  vec_t tbl [4];

  localparam logic [79:0] K_EQ = 80'h3c1a_5e77_0f92_d4b8_6a01;
  localparam logic [79:0] V_EQ = 80'h9e37_79b9_7f4a_7c15_f39c;

  initial begin
    int          bn, nc, accn;
    logic        acc;
    logic [255:0] bits;

    tbl[0] = '{80'h0, 80'h0, 8, 0, 144};
    tbl[1] = '{K_EQ, V_EQ, 16, 50, 144};
    tbl[2] = '{{80{1'b1}}, {80{1'b1}}, 12, 25, 144};
    tbl[3] = '{80'h8000_0000_0000_0000_0001, 80'h0000_0000_0001_0000_8000, 20, 70, 144};

    {key8, iv8, key1, iv1, key64, iv64, keyl, ivl} = '0;
    {load8, load1, load64, loadl} = '0;
    {if8.s_valid, if8.s_last, if8.m_ready, if1.s_valid, if1.s_last, if1.m_ready} = '0;
    {if64.s_valid, if64.s_last, if64.m_ready, ifl.s_valid, ifl.s_last, ifl.m_ready} = '0;
    if8.s_data = '0; if1.s_data = '0; if64.s_data = '0; ifl.s_data = '0;
    hold_v = 1'b0; hold_d = '0;

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy8, ready8, err8, if8.s_ready, if8.m_valid, if8.m_last, if8.m_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Golden key=0/iv=0 at W=1, then W equivalence on one key/IV.
    ksr = model_ks(80'h0, 80'h0);
    run_w1(80'h0, 80'h0, bn, bits);
    check("w1_busy", bn, 1152);
    check("w1_golden_256", bits, ksr[255:0]);
    ksr = model_ks(K_EQ, V_EQ);
    run_w1(K_EQ, V_EQ, bn, bits);
    check("w1_eq_stream", bits, ksr[255:0]);
    run_w64(K_EQ, V_EQ, bn, bits);
    check("w64_busy", bn, 18);
    check("w64_eq_stream", bits, ksr[255:0]);

    // Table vectors on W=8 with random backpressure.
    foreach (tbl[t]) begin
      load_main(tbl[t].key, tbl[t].iv, bn);
      check("w8_busy", bn, tbl[t].exp_busy);
      ksr = model_ks(tbl[t].key, tbl[t].iv);
      for (int i = 0; i < tbl[t].nw; i++) begin
        din[i]  = 8'($urandom);
        dexp[i] = din[i] ^ ksr[i*8 +: 8];
      end
      send(tbl[t].nw, tbl[t].stall, nc);
      if (tbl[t].stall == 0) check("full_rate_cycles", nc, tbl[t].nw);
      drain();
    end

    // Round trip: encrypt 32 words, reload, decrypt the captured ciphertext.
    load_main(V_EQ, K_EQ, bn);
    ksr = model_ks(V_EQ, K_EQ);
    for (int i = 0; i < 32; i++) begin
      pt[i]   = 8'($urandom);
      din[i]  = pt[i];
      dexp[i] = pt[i] ^ ksr[i*8 +: 8];
    end
    capq.delete();
    send(32, 30, nc);
    drain();
    check("rt_cap_count", capq.size(), 32);
    load_main(V_EQ, K_EQ, bn);
    for (int i = 0; i < 32; i++) begin
      din[i]  = (capq.size() > 0) ? capq.pop_front() : 8'h00;
      dexp[i] = pt[i];
    end
    send(32, 30, nc);
    drain();

    // Load while a word is pending and s_valid is high.
    load_main(K_EQ, V_EQ, bn);
    cyc8(1'b1, 8'h5a, 1'b0, 8'h00, 1'b0, acc);
    check("pre_load_accept", {acc, if8.m_valid}, 2'b11);
    load8 = 1'b1; if8.s_valid = 1'b1; if8.m_ready = 1'b0;
    #1;
    check("s_ready_during_load", if8.s_ready, 0);
    @(negedge clk);
    load8 = 1'b0; if8.s_valid = 1'b0; sbq.delete(); hold_v = 1'b0;
    check("load_clears_pending", {if8.m_valid, busy8}, 2'b01);
    count_busy8(bn);
    check("reload_busy", bn, 144);

    // Reset in the middle of warm-up.
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_warmup", {busy8, ready8, err8, if8.s_ready, if8.m_valid, if8.m_last, if8.m_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Word limit of 4.
    keyl = K_EQ; ivl = V_EQ; loadl = 1'b1; ifl.m_ready = 1'b1;
    @(negedge clk);
    loadl = 1'b0;
    for (int i = 0; i < 300 && !readyl; i++) @(negedge clk);
    accn = 0;
    for (int i = 0; i < 6; i++) begin
      ifl.s_valid = 1'b1; ifl.s_data = 8'(i); ifl.s_last = 1'b0;
      #1;
      if (ifl.s_ready) accn++;
      @(negedge clk);
    end
    ifl.s_valid = 1'b0;
    @(negedge clk);
    check("limit_accepts", accn, 4);
    check("limit_flags", {errl, readyl, ifl.s_ready, ifl.m_valid}, 4'b1000);
    loadl = 1'b1;
    @(negedge clk);
    loadl = 1'b0;
    check("limit_reload", {errl, busyl}, 2'b01);
    for (int i = 0; i < 300 && !readyl; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ifl.s_valid = 1'b1; ifl.s_data = 8'(i); ifl.s_last = (i == 3);
      @(negedge clk);
    end
    ifl.s_valid = 1'b0; ifl.s_last = 1'b0;
    @(negedge clk);
    check("limit_last_wins", {errl, readyl, busyl}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
